compare_debounce: RTL and testbench
===================================

# compare_debounce

Downstream consumer of the 4-bit relational comparator's `gt`/`lt`/`eq` flags. Qualifies a stream of comparison results into a debounced "above" level with hysteresis, emits one-cycle rise/fall pulses, and keeps a saturating count of rising transitions. Typical use: sample-vs-threshold detection, where a single noisy comparison must not toggle downstream logic.

## Interface
- `DEBOUNCE`, default 4: consecutive qualifying samples needed to change level; legal range 1..15.
- `CNT_W`, default 8: width of the rise counter.

- `clk` input 1: sole clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `gt`/`lt`/`eq` carry a sample this cycle.
- `gt` input 1: comparator result a > b.
- `lt` input 1: comparator result a < b.
- `eq` input 1: comparator result a == b.
- `cnt_clr` input 1: synchronous clear of `rise_count`.
- `out_high` output 1: debounced level; 1 means "above".
- `rise` output 1: one-cycle pulse on the low-to-high level change.
- `fall` output 1: one-cycle pulse on the high-to-low level change.
- `rise_count` output CNT_W: saturating count of rises.
- `err` output 1: one-cycle pulse on an illegal flag combination.

## Operation
- All outputs are registered. Reset value of every output and of the internal state is 0; the state machine resets to `LOW`.
- Samples are taken only on edges where `in_valid`=1. Cycles with `in_valid`=0 change nothing and do not break a run.
- Legal sample: exactly one of `gt`/`lt`/`eq` is set. Any other combination is illegal: `err`=1 for one cycle; state and run counter are unchanged.
- Sample classes: ABOVE = `gt`. BELOW = `lt`, or `eq` (see Configuration). NEUTRAL = `eq` only when the macro is defined.
- State machine (`LOW`, `ARM_HIGH`, `HIGH`, `ARM_LOW`) with run counter `run` (4 bits):
  - `LOW`: ABOVE sets `run`=1 and moves to `ARM_HIGH`. If `DEBOUNCE`=1, it moves straight to `HIGH` and pulses `rise`. BELOW stays in `LOW`.
  - `ARM_HIGH`: ABOVE increments `run`. When `run` reaches `DEBOUNCE`, move to `HIGH`, pulse `rise`, clear `run`. BELOW moves back to `LOW` and clears `run`.
  - `HIGH`: BELOW is handled like ABOVE in `LOW`, mirrored: go to `ARM_LOW` (or straight to `LOW` with a `fall` pulse if `DEBOUNCE`=1). ABOVE stays in `HIGH`.
  - `ARM_LOW`: BELOW increments `run`. When `run` reaches `DEBOUNCE`, move to `LOW`, pulse `fall`, clear `run`. ABOVE moves back to `HIGH` and clears `run`.
  - NEUTRAL in any state: no change.
- `out_high` is 1 in `HIGH` and `ARM_LOW`, and 0 in `LOW` and `ARM_HIGH`.
- `rise_count` increments on every `rise` and saturates at all-ones (no wrap).
- If `cnt_clr` and an increment occur on the same edge, clear wins and `rise_count` becomes 0; the `rise` pulse and `out_high` are unaffected.
- `rise` and `fall` are never both 1 in the same cycle.

## Timing
- Latency:
  - `out_high`, `rise` and `fall` update on the same edge that samples the `DEBOUNCE`-th qualifying input; they are visible in the following cycle.
  - `rise` and `fall` last exactly one cycle.
  - `err` asserts in the cycle after the illegal sample and lasts one cycle.
  - `rise_count` updates on the same edge as `rise`.
- Reset:
  - `rst_n` low clears all state and outputs immediately, independent of `clk`, including mid-run and mid-pulse.
  - The first legal sample after release is handled from `LOW` with `run`=0.
- Back-to-back samples, one per cycle, are fully supported. No backpressure.

## Configuration
- Macro: `COMPARE_DEBOUNCE_EQ_NEUTRAL_EN`.
- Undefined (default): `eq` is classed BELOW. "Above" means strictly greater; equality counts toward falling and cancels a rise in progress.
- Defined: `eq` is NEUTRAL. It holds the state and `run`, so equality neither advances nor breaks a run in either direction.

## Test plan
- **Basic rise:** `DEBOUNCE`=4, reset, then 4 consecutive valid `gt` samples -> after the 4th edge `out_high`=1 and `rise`=1 for one cycle; `rise_count`=1.
- **Broken run:** `gt`,`gt`,`gt`,`lt`, then `gt`×4 -> no `rise` after the first 4 samples; `rise` after the 8th sample; `rise_count`=1.
- **Equality handling:** from `HIGH`, 4 `eq` samples -> macro undefined: `fall` pulse and `out_high`=0. Macro defined: `out_high` stays 1, no `fall`.
- **Illegal flags and gaps:** `gt`, `gt`, {`gt`=1,`lt`=1}, idle cycles with `in_valid`=0, `gt`, `gt` -> `err` pulses once; `rise` occurs on the last `gt`.
- **Clear vs increment:** `cnt_clr`=1 on the same edge as a rise -> `rise_count`=0, `rise`=1, `out_high`=1. With `CNT_W`=2, 5 rise/fall cycles -> `rise_count`=3 (saturated).
- **Reset mid-operation:** `rst_n` driven low in `ARM_HIGH` with `run`=3 -> all outputs 0 immediately. After release, 3 `gt` samples give no `rise`; the 4th gives `rise`.

Source files
------------

// File: rtl/compare_debounce.sv
// Debounces a stream of gt/lt/eq comparator flags into a hysteretic "above" level,
// with rise/fall pulses and a saturating rise counter. Optional macro: COMPARE_DEBOUNCE_EQ_NEUTRAL_EN.
`timescale 1ns/1ps

module compare_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  input  logic             cnt_clr,
  output logic             out_high,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_count,
  output logic             err
);

  typedef enum logic [1:0] {LOW, ARM_HIGH, HIGH, ARM_LOW} state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  state_t     state, state_nx;
  logic [3:0] run, run_nx, run_inc;
  logic       rise_nx, fall_nx;
  logic       legal, above, below, done;

  assign legal = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
  assign above = in_valid & legal & gt;
`ifdef COMPARE_DEBOUNCE_EQ_NEUTRAL_EN
  // Equality is neutral: it neither advances nor breaks a run.
  assign below = in_valid & legal & lt;
`else
  assign below = in_valid & legal & (lt | eq);
`endif

  assign run_inc = run + 4'd1;
  assign done    = (run_inc == DEB);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    run_nx   = run;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      LOW: if (above) begin
        if (DEB == 4'd1) begin
          state_nx = HIGH;
          rise_nx  = 1'b1;
        end else begin
          state_nx = ARM_HIGH;
          run_nx   = 4'd1;
        end
      end
      ARM_HIGH: if (above) begin
        if (done) begin
          state_nx = HIGH;
          rise_nx  = 1'b1;
          run_nx   = 4'd0;
        end else begin
          run_nx = run_inc;
        end
      end else if (below) begin
        state_nx = LOW;
        run_nx   = 4'd0;
      end
      HIGH: if (below) begin
        if (DEB == 4'd1) begin
          state_nx = LOW;
          fall_nx  = 1'b1;
        end else begin
          state_nx = ARM_LOW;
          run_nx   = 4'd1;
        end
      end
      ARM_LOW: if (below) begin
        if (done) begin
          state_nx = LOW;
          fall_nx  = 1'b1;
          run_nx   = 4'd0;
        end else begin
          run_nx = run_inc;
        end
      end else if (above) begin
        state_nx = HIGH;
        run_nx   = 4'd0;
      end
      default: begin
        state_nx = LOW;
        run_nx   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOW;
      run        <= 4'd0;
      out_high   <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      err        <= 1'b0;
      rise_count <= '0;
    end else begin
      state    <= state_nx;
      run      <= run_nx;
      out_high <= (state_nx == HIGH) || (state_nx == ARM_LOW);
      rise     <= rise_nx;
      fall     <= fall_nx;
      err      <= in_valid & ~legal;
      // Clear takes priority over a coincident rise.
      if (cnt_clr)
        rise_count <= '0;
      else if (rise_nx && (rise_count != '1))
        rise_count <= rise_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_compare_debounce.sv
// Directed self-checking bench for compare_debounce; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps

module tb_compare_debounce;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, gt, lt, eq, cnt_clr;
  logic       out_high, rise, fall, err;
  logic [7:0] rise_count;
  logic       out_high_s, rise_s, fall_s, err_s;
  logic [1:0] rise_count_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  compare_debounce #(.DEBOUNCE(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .lt(lt), .eq(eq),
    .cnt_clr(cnt_clr), .out_high(out_high), .rise(rise), .fall(fall),
    .rise_count(rise_count), .err(err)
  );

  compare_debounce #(.DEBOUNCE(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gt(gt), .lt(lt), .eq(eq),
    .cnt_clr(cnt_clr), .out_high(out_high_s), .rise(rise_s), .fall(fall_s),
    .rise_count(rise_count_s), .err(err_s)
  );

  task automatic sample(input logic g, input logic l, input logic e, input logic clr);
    in_valid = 1'b1; gt = g; lt = l; eq = e; cnt_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; gt = 1'b0; lt = 1'b0; eq = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic idle(input logic g, input logic l, input logic clr);
    in_valid = 1'b0; gt = g; lt = l; eq = 1'b0; cnt_clr = clr;
    @(posedge clk); #1;
    gt = 1'b0; lt = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; gt = 1'b0; lt = 1'b0; eq = 1'b0; cnt_clr = 1'b0;
    #3;
    if ({out_high, rise, fall, err, rise_count} !== 12'h000) begin
      $display("FAIL reset_main: got %h want 000", {out_high, rise, fall, err, rise_count}); n_bad++;
    end
    n_cmp++;
    if ({out_high_s, rise_s, fall_s, err_s, rise_count_s} !== 6'h00) begin
      $display("FAIL reset_sat: got %h want 00", {out_high_s, rise_s, fall_s, err_s, rise_count_s}); n_bad++;
    end
    n_cmp++;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rise();
    do_reset();
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0);
    if ({out_high, rise} !== 2'b00) begin
      $display("FAIL rise_early: got %b want 00", {out_high, rise}); n_bad++;
    end
    n_cmp++;
    sample(1, 0, 0, 0);
    if ({out_high, rise, fall, rise_count} !== {3'b110, 8'd1}) begin
      $display("FAIL rise_4th: got %b/%0d want 110/1", {out_high, rise, fall}, rise_count); n_bad++;
    end
    n_cmp++;
    idle(0, 0, 0);
    if ({out_high, rise} !== 2'b10) begin
      $display("FAIL rise_one_cycle: got %b want 10", {out_high, rise}); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) sample(0, 1, 0, 0);
    if ({out_high, fall} !== 2'b10) begin
      $display("FAIL fall_early: got %b want 10", {out_high, fall}); n_bad++;
    end
    n_cmp++;
    sample(0, 1, 0, 0);
    if ({out_high, rise, fall} !== 3'b001) begin
      $display("FAIL fall_4th: got %b want 001", {out_high, rise, fall}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_broken_run();
    do_reset();
    sample(1, 0, 0, 0); sample(1, 0, 0, 0); sample(1, 0, 0, 0); sample(0, 1, 0, 0);
    if ({out_high, rise} !== 2'b00) begin
      $display("FAIL broken_no_rise: got %b want 00", {out_high, rise}); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0);
    if (rise !== 1'b0) begin
      $display("FAIL broken_restart: rise got %b want 0", rise); n_bad++;
    end
    n_cmp++;
    sample(1, 0, 0, 0);
    if ({out_high, rise, rise_count} !== {2'b11, 8'd1}) begin
      $display("FAIL broken_rise_8th: got %b/%0d want 11/1", {out_high, rise}, rise_count); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_equality();
    do_reset();
    for (int i = 0; i < 4; i++) sample(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) sample(0, 0, 1, 0);
    if ({out_high, fall} !== 2'b10) begin
      $display("FAIL eq_three: got %b want 10", {out_high, fall}); n_bad++;
    end
    n_cmp++;
    sample(0, 0, 1, 0);
`ifdef COMPARE_DEBOUNCE_EQ_NEUTRAL_EN
    if ({out_high, fall} !== 2'b10) begin
      $display("FAIL eq_neutral_hold: got %b want 10", {out_high, fall}); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) sample(0, 1, 0, 0);
    if ({out_high, fall} !== 2'b01) begin
      $display("FAIL eq_neutral_lt_fall: got %b want 01", {out_high, fall}); n_bad++;
    end
    n_cmp++;
`else
    if ({out_high, fall} !== 2'b01) begin
      $display("FAIL eq_below_fall: got %b want 01", {out_high, fall}); n_bad++;
    end
    n_cmp++;
`endif
  endtask

  task automatic test_illegal_gaps();
    do_reset();
    sample(1, 0, 0, 0); sample(1, 0, 0, 0);
    sample(1, 1, 0, 0);
    if ({err, rise, out_high} !== 3'b100) begin
      $display("FAIL illegal_gtlt: got %b want 100", {err, rise, out_high}); n_bad++;
    end
    n_cmp++;
    idle(1, 1, 0);
    if (err !== 1'b0) begin
      $display("FAIL err_one_cycle: got %b want 0", err); n_bad++;
    end
    n_cmp++;
    idle(1, 0, 0); idle(0, 0, 0);
    sample(0, 0, 0, 0);
    if (err !== 1'b1) begin
      $display("FAIL illegal_none: got %b want 1", err); n_bad++;
    end
    n_cmp++;
    sample(1, 0, 0, 0);
    if ({err, rise} !== 2'b00) begin
      $display("FAIL gap_third_gt: got %b want 00", {err, rise}); n_bad++;
    end
    n_cmp++;
    sample(1, 0, 0, 0);
    if ({rise, out_high} !== 2'b11) begin
      $display("FAIL gap_rise: got %b want 11", {rise, out_high}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0);
    sample(1, 0, 0, 1);
    if ({out_high, rise, rise_count} !== {2'b11, 8'd0}) begin
      $display("FAIL clr_vs_inc: got %b/%0d want 11/0", {out_high, rise}, rise_count); n_bad++;
    end
    n_cmp++;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) sample(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) sample(0, 1, 0, 0);
    end
    if (rise_count !== 8'd5) begin
      $display("FAIL count_five: got %0d want 5", rise_count); n_bad++;
    end
    n_cmp++;
    if (rise_count_s !== 2'd3) begin
      $display("FAIL count_saturate: got %0d want 3", rise_count_s); n_bad++;
    end
    n_cmp++;
    idle(0, 0, 1);
    if ({rise_count, rise_count_s} !== 10'd0) begin
      $display("FAIL clr_alone: got %0d/%0d want 0/0", rise_count, rise_count_s); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) sample(1, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    if ({out_high, rise, fall, err, rise_count} !== 12'h000) begin
      $display("FAIL reset_mid_pulse: got %h want 000", {out_high, rise, fall, err, rise_count}); n_bad++;
    end
    n_cmp++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    if ({out_high, rise, fall, err, rise_count} !== 12'h000) begin
      $display("FAIL reset_mid_run: got %h want 000", {out_high, rise, fall, err, rise_count}); n_bad++;
    end
    n_cmp++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) sample(1, 0, 0, 0);
    if ({out_high, rise} !== 2'b00) begin
      $display("FAIL reset_run_cleared: got %b want 00", {out_high, rise}); n_bad++;
    end
    n_cmp++;
    sample(1, 0, 0, 0);
    if ({out_high, rise, rise_count} !== {2'b11, 8'd1}) begin
      $display("FAIL reset_then_rise: got %b/%0d want 11/1", {out_high, rise}, rise_count); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_basic_rise();
    test_broken_run();
    test_equality();
    test_illegal_gaps();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
